parser_lit_pipe: RTL
====================

PARSER_LIT_PIPE -- requirements
Module: parser_lit_pipe

Interface
REQ-001 SHALL have parameter BANK_BYTES, default 8, the byte width of one bank word (power of two).
REQ-002 SHALL have parameter NUM_BANKS, default 16, the number of interleaved banks (power of two).
REQ-003 SHALL have parameter IN_BYTES, default 16, the bytes per input beat (a multiple of BANK_BYTES).
REQ-004 SHALL have parameter ADDR_W, default 16, the byte-address width; ROW_W = ADDR_W - log2(BANK_BYTES) - log2(NUM_BANKS), default 9.
REQ-005 SHALL have parameter LEN_W, default 6, the width of the token length field (length minus 1, so up to 2^LEN_W bytes).
REQ-006 SHALL define derived constant PORTS = IN_BYTES/BANK_BYTES + 1, default 3.
REQ-007 clk  input  1  the single clock; all logic is clocked on the rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 data_in  input  IN_BYTES*8  the literal bytes; byte 0 is at the MSBs.
REQ-010 length_in  input  LEN_W  the token length minus 1; sampled only on a header beat.
REQ-011 address_in  input  ADDR_W  the destination byte address; sampled only on a header beat. Bits [2:0] give the shift, [6:3] the bank, and the upper bits the row.
REQ-012 valid_in / ready_out  input / output  1 each  the input handshake.
REQ-013 wr_data  output  PORTS*BANK_BYTES*8  the per-port bank word.
REQ-014 wr_mask  output  PORTS*BANK_BYTES  the per-port byte enables; the MSB is the lowest byte address.
REQ-015 wr_row  output  PORTS*ROW_W  the per-port bank row address.
REQ-016 wr_sel  output  PORTS*NUM_BANKS  the per-port one-hot bank select; it is all-zero when the port is unused.
REQ-017 valid_out / ready_in  output / input  1 each  the output handshake.

Function
REQ-018 Input transfer SHALL occur when valid_in and ready_out are both high; output transfer SHALL occur when valid_out and ready_in are both high.
REQ-019 The FSM SHALL have two states, IDLE and BODY.
  - In IDLE, an accepted beat is a header: the block latches the address and sets remaining = length_in + 1.
  - If remaining > IN_BYTES after the header, the FSM goes to BODY; otherwise it stays in IDLE.
REQ-020 In BODY, each accepted beat SHALL advance the address by IN_BYTES and reduce remaining by IN_BYTES.
  - The FSM returns to IDLE on the beat where remaining <= IN_BYTES.
  - length_in and address_in are ignored in BODY.
REQ-021 Bytes valid in a beat SHALL be min(remaining, IN_BYTES), counted from byte 0; the remaining bytes of that beat are masked off.
REQ-022 Each beat SHALL be shifted right by (address mod BANK_BYTES) bytes and split across PORTS consecutive banks starting at the address's bank.
  - The bank index wraps modulo NUM_BANKS.
  - The row increments on each bank wrap and itself wraps modulo 2^ROW_W.
REQ-023 A port whose mask is all-zero SHALL drive wr_sel = 0 and wr_data = 0.
REQ-024 Latency SHALL be exactly 2 cycles from input transfer to valid_out when ready_in is held high; throughput is 1 beat per cycle.
REQ-025 With ready_in low, all outputs SHALL hold stable; ready_out SHALL go low only when both pipeline stages are full, and no beat is lost or duplicated.
REQ-026 ready_out SHALL NOT depend combinationally on valid_in.
REQ-027 A header accepted in the same cycle that the previous token's last beat leaves the output SHALL be handled without a bubble.

Reset
REQ-028 While rst is high:
  - The FSM goes to IDLE, remaining = 0, and both stage-valid flags clear.
  - valid_out = 0 and ready_out = 0.
  - wr_mask and wr_sel = 0; wr_data and wr_row = 0.
REQ-029 ready_out SHALL be 1 in the first cycle after rst falls.
REQ-030 A reset asserted mid-token SHALL discard the partial token; the next accepted beat is treated as a header.

Configuration
REQ-031 The feature SHALL be controlled by macro PARSER_LIT_STATS_EN.
REQ-032 When PARSER_LIT_STATS_EN is defined, the block SHALL add two outputs:
  - stat_tokens, 32 bits, incremented once per header beat accepted.
  - stat_beats, 32 bits, incremented once per output transfer.
  Both counters saturate at all-ones and are cleared by rst.
REQ-033 When PARSER_LIT_STATS_EN is undefined, the ports and counters SHALL be absent and behaviour is otherwise identical.

Verification
REQ-034 Single short token: header addr 0x0005, len 3, data bytes A0 A1 A2 A3 -> after 2 cycles:
  - port0: bank 0, row 0, mask 8'h07, bytes A0..A2 in bytes 5..7.
  - port1: bank 1, mask 8'h80, A3 in byte 0.
  - port2: sel 0.
REQ-035 Bank wrap: addr 0x007C, len 15 ->
  - port0: bank 15, row 0, mask 8'h0F.
  - port1: bank 0, row 1, mask 8'hFF.
  - port2: bank 1, row 1, mask 8'hF0.
REQ-036 Multi-beat token: addr 0x0000, len 39, three beats ->
  - Outputs at rows/banks 0/0-1, 0/2-3, 0/4; the third beat has port0 mask 8'hFF and port1 sel 0.
  - FSM is back in IDLE after beat 3.
REQ-037 Backpressure: a continuous stream with ready_in low for 3 cycles mid-token ->
  - Outputs are held constant and ready_out drops after 2 accepted beats.
  - The output sequence is identical to the no-stall case.
REQ-038 Reset mid-token: rst pulsed during beat 2 of a len-39 token, then a new header at addr 0x0100 len 7 ->
  - Only the new token is output: bank 0, row 2, mask 8'hFF.
  - With PARSER_LIT_STATS_EN, stat_tokens = 1.

Source files
------------

// File: rtl/parser_lit_pipe.sv
// Literal-copy pipeline: aligns token bytes onto PORTS consecutive interleaved bank ports.
// Optional macro PARSER_LIT_STATS_EN adds stat_tokens/stat_beats; per-port buses hold port p at [p*W +: W].
module parser_lit_pipe #(
    parameter int unsigned BANK_BYTES = 8,
    parameter int unsigned NUM_BANKS  = 16,
    parameter int unsigned IN_BYTES   = 16,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned LEN_W      = 6,
    localparam int unsigned BB_W      = $clog2(BANK_BYTES),
    localparam int unsigned NB_W      = $clog2(NUM_BANKS),
    localparam int unsigned ROW_W     = ADDR_W - BB_W - NB_W,
    localparam int unsigned PORTS     = IN_BYTES / BANK_BYTES + 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [IN_BYTES*8-1:0]           data_in,
    input  logic [LEN_W-1:0]                length_in,
    input  logic [ADDR_W-1:0]               address_in,
    input  logic                            valid_in,
    output logic                            ready_out,
    output logic [PORTS*BANK_BYTES*8-1:0]   wr_data,
    output logic [PORTS*BANK_BYTES-1:0]     wr_mask,
    output logic [PORTS*ROW_W-1:0]          wr_row,
    output logic [PORTS*NUM_BANKS-1:0]      wr_sel,
    output logic                            valid_out,
    input  logic                            ready_in
`ifdef PARSER_LIT_STATS_EN
    ,
    output logic [31:0]                     stat_tokens,
    output logic [31:0]                     stat_beats
`endif
);

    localparam int unsigned REM_W  = LEN_W + 1;
    localparam int unsigned WIDE_B = PORTS * BANK_BYTES;
    localparam logic [REM_W-1:0] IN_R = REM_W'(IN_BYTES);

    typedef enum logic {StIdle, StBody} state_e;

    state_e              state_q, state_d;
    logic [REM_W-1:0]    rem_q, rem_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;

    logic                accept, is_header;
    logic                s1_en, s2_en;
    logic [REM_W-1:0]    cur_rem, beat_cnt;
    logic [ADDR_W-1:0]   cur_addr;
    logic [IN_BYTES-1:0] beat_mask;
    logic [IN_BYTES*8-1:0] byte_en;

    logic                  s1_v_q;
    logic [IN_BYTES*8-1:0] s1_data_q;
    logic [IN_BYTES-1:0]   s1_mask_q;
    logic [ADDR_W-1:0]     s1_addr_q;

    logic                             s2_v_q;
    logic [PORTS*BANK_BYTES*8-1:0]    wr_data_q, wr_data_d;
    logic [PORTS*BANK_BYTES-1:0]      wr_mask_q, wr_mask_d;
    logic [PORTS*ROW_W-1:0]           wr_row_q, wr_row_d;
    logic [PORTS*NUM_BANKS-1:0]       wr_sel_q, wr_sel_d;

    logic [BB_W-1:0]       s1_shift;
    logic [NB_W-1:0]       s1_bank;
    logic [ROW_W-1:0]      s1_row;
    logic [WIDE_B*8-1:0]   wide_data;
    logic [WIDE_B-1:0]     wide_mask;
    logic [BANK_BYTES-1:0] port_mask;
    logic [NB_W:0]         bank_sum;

    // Stage 2 moves when it is empty or drained; stage 1 moves when stage 2 can take it.
    assign s2_en     = ~s2_v_q | ready_in;
    assign s1_en     = ~s1_v_q | s2_en;
    assign ready_out = ~rst & s1_en;
    assign accept    = valid_in & ready_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        if (accept) begin
            if (cur_rem > IN_R) begin
                state_d = StBody;
                rem_d   = cur_rem - IN_R;
                addr_d  = cur_addr + ADDR_W'(IN_BYTES);
            end else begin
                state_d = StIdle;
                rem_d   = '0;
            end
        end
    end

    always_comb begin
        if (state_q == StIdle) begin
            cur_rem  = REM_W'(length_in) + REM_W'(1);
            cur_addr = address_in;
        end else begin
            cur_rem  = rem_q;
            cur_addr = addr_q;
        end
        beat_cnt  = (cur_rem > IN_R) ? IN_R : cur_rem;
        beat_mask = ~({IN_BYTES{1'b1}} >> beat_cnt);
        is_header = accept & (state_q == StIdle);
        byte_en   = '0;
        for (int i = 0; i < IN_BYTES; i++) begin
            byte_en[i*8 +: 8] = {8{beat_mask[i]}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            addr_q <= '0;
        end else begin
            rem_q  <= rem_d;
            addr_q <= addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s1_data_q <= '0;
            s1_mask_q <= '0;
            s1_addr_q <= '0;
        end else if (s1_en) begin
            s1_v_q <= accept;
            if (accept) begin
                s1_data_q <= data_in & byte_en;
                s1_mask_q <= beat_mask;
                s1_addr_q <= cur_addr;
            end
        end
    end

    always_comb begin
        wr_data_d = '0;
        wr_mask_d = '0;
        wr_row_d  = '0;
        wr_sel_d  = '0;
        port_mask = '0;
        bank_sum  = '0;
        s1_shift  = s1_addr_q[BB_W-1:0];
        s1_bank   = s1_addr_q[BB_W+NB_W-1:BB_W];
        s1_row    = s1_addr_q[ADDR_W-1:BB_W+NB_W];
        wide_data = {s1_data_q, {(BANK_BYTES*8){1'b0}}} >> {s1_shift, 3'b000};
        wide_mask = {s1_mask_q, {BANK_BYTES{1'b0}}} >> s1_shift;
        for (int p = 0; p < PORTS; p++) begin
            port_mask = wide_mask[(PORTS-1-p)*BANK_BYTES +: BANK_BYTES];
            bank_sum  = {1'b0, s1_bank} + (NB_W+1)'(p);
            if (s1_v_q && port_mask != '0) begin
                wr_mask_d[p*BANK_BYTES +: BANK_BYTES] = port_mask;
                wr_data_d[p*BANK_BYTES*8 +: BANK_BYTES*8] =
                    wide_data[(PORTS-1-p)*BANK_BYTES*8 +: BANK_BYTES*8];
                wr_sel_d[p*NUM_BANKS +: NUM_BANKS] = NUM_BANKS'(1) << bank_sum[NB_W-1:0];
                // Carry out of the bank index bumps the row.
                wr_row_d[p*ROW_W +: ROW_W] = s1_row + ROW_W'(bank_sum[NB_W]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v_q    <= 1'b0;
            wr_data_q <= '0;
            wr_mask_q <= '0;
            wr_row_q  <= '0;
            wr_sel_q  <= '0;
        end else if (s2_en) begin
            s2_v_q    <= s1_v_q;
            wr_data_q <= wr_data_d;
            wr_mask_q <= wr_mask_d;
            wr_row_q  <= wr_row_d;
            wr_sel_q  <= wr_sel_d;
        end
    end

    assign valid_out = s2_v_q;
    assign wr_data   = wr_data_q;
    assign wr_mask   = wr_mask_q;
    assign wr_row    = wr_row_q;
    assign wr_sel    = wr_sel_q;

`ifdef PARSER_LIT_STATS_EN
    logic [31:0] stat_tokens_q, stat_beats_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_tokens_q <= '0;
            stat_beats_q  <= '0;
        end else begin
            if (is_header && stat_tokens_q != '1) begin
                stat_tokens_q <= stat_tokens_q + 32'd1;
            end
            if (valid_out && ready_in && stat_beats_q != '1) begin
                stat_beats_q <= stat_beats_q + 32'd1;
            end
        end
    end

    assign stat_tokens = stat_tokens_q;
    assign stat_beats  = stat_beats_q;
`endif

endmodule
